pulse_period_meter: RTL and testbench

Measures the spacing, in clock cycles, between successive single-cycle pulses on `pulse_in` and reports each measured period through a valid/ready output port. It is the receive-side counterpart of the team's periodic pulse generator. It sits after a pulse source or strobe to verify a generator's period, recover a divider setting, or flag a missing or irregular strobe. It also reports saturation, dropped results, and a lock indicator for a steady period.

---
 rtl/pulse_period_meter.sv | 144 ++++++++++++++
 tb/tb_pulse_period_meter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_meter.sv
// pulse_period_meter
// Measures the spacing, in clk cycles, between successive pulses on pulse_in
// and presents each measured period on a valid/ready result port.
//
// Ports:
//   clk       in   clock, all logic on rising edge
//   rst       in   asynchronous active-high reset
//   ena       in   measurement enable; low returns to IDLE, result port retained
//   pulse_in  in   event strobe, one event per cycle sampled high
//   period    out  [N-1:0] last captured period (saturates at 2^N-1)
//   overflow  out  period is saturated (interval ran past 2^N-1)
//   valid     out  period/overflow hold an unconsumed result
//   ready     in   consumer accepts the result when valid & ready
//   lost      out  sticky: a result was overwritten before acceptance
//   locked    out  last two captured periods equal and neither saturated
module pulse_period_meter #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         pulse_in,
    input  logic         ready,
    output logic [N-1:0] period,
    output logic         overflow,
    output logic         valid,
    output logic         lost,
    output logic         locked
);

    localparam logic [0:0]   ST_IDLE    = 1'b0;
    localparam logic [0:0]   ST_MEASURE = 1'b1;
    localparam logic [N-1:0] CNT_MAX    = {N{1'b1}};
    localparam logic [N-1:0] CNT_ONE    = N'(1);

    logic [0:0]   state,       state_nx;
    logic [N-1:0] cnt,         cnt_nx;
    logic         sat,         sat_nx;
    logic [N-1:0] period_nx;
    logic         overflow_nx;
    logic         valid_nx;
    logic         lost_nx;
    logic         locked_nx;
    logic [N-1:0] prev_period, prev_period_nx;
    // prev_ok: a previous capture exists in this session and it did not saturate
    logic         prev_ok,     prev_ok_nx;
    logic         xfer;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            sat         <= 1'b0;
            period      <= '0;
            overflow    <= 1'b0;
            valid       <= 1'b0;
            lost        <= 1'b0;
            locked      <= 1'b0;
            prev_period <= '0;
            prev_ok     <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            sat         <= sat_nx;
            period      <= period_nx;
            overflow    <= overflow_nx;
            valid       <= valid_nx;
            lost        <= lost_nx;
            locked      <= locked_nx;
            prev_period <= prev_period_nx;
            prev_ok     <= prev_ok_nx;
        end
    end

    // Next-state, counter and result-port logic
    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        sat_nx         = sat;
        period_nx      = period;
        overflow_nx    = overflow;
        valid_nx       = valid;
        lost_nx        = lost;
        locked_nx      = locked;
        prev_period_nx = prev_period;
        prev_ok_nx     = prev_ok;

        xfer = valid & ready;

        // Accepted result leaves the port; lost was reported alongside it
        if (xfer) begin
            valid_nx = 1'b0;
            lost_nx  = 1'b0;
        end

        if (!ena) begin
            // Session ends; the result port keeps its contents for draining
            state_nx   = ST_IDLE;
            cnt_nx     = '0;
            sat_nx     = 1'b0;
            locked_nx  = 1'b0;
            prev_ok_nx = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // First pulse of a session is only a reference
                    if (pulse_in) begin
                        state_nx   = ST_MEASURE;
                        cnt_nx     = CNT_ONE;
                        sat_nx     = 1'b0;
                        prev_ok_nx = 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if (pulse_in) begin
                        period_nx   = cnt;
                        overflow_nx = sat;
                        valid_nx    = 1'b1;
                        // Overwriting an unaccepted result; a same-cycle
                        // transfer drains the old value, so nothing is lost
                        if (valid && !ready) begin
                            lost_nx = 1'b1;
                        end
                        locked_nx      = (cnt == prev_period) & ~sat & prev_ok;
                        prev_period_nx = cnt;
                        prev_ok_nx     = ~sat;
                        cnt_nx         = CNT_ONE;
                        sat_nx         = 1'b0;
                    end else if (cnt != CNT_MAX) begin
                        cnt_nx = cnt + CNT_ONE;
                    end else begin
                        // Hold at the ceiling instead of wrapping
                        sat_nx = 1'b1;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Self-checking bench for pulse_period_meter: directed scenarios plus a
// randomized run compared against an interval-based reference model.
module tb_pulse_period_meter;

    localparam int N = 8;
    localparam int PMAX = (1 << N) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         ena;
    logic         pulse_in;
    logic         ready;
    logic [N-1:0] period;
    logic         overflow;
    logic         valid;
    logic         lost;
    logic         locked;

    int checks = 0;
    int errors = 0;

    // Reference model: works on pulse timestamps, not on a running counter
    int cyc;
    int ref_cyc;
    bit have_ref;
    bit prev_good;
    int prev_per;
    int m_period;
    bit m_ovf;
    bit m_valid;
    bit m_lost;
    bit m_locked;

    pulse_period_meter #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .pulse_in (pulse_in),
        .ready    (ready),
        .period   (period),
        .overflow (overflow),
        .valid    (valid),
        .lost     (lost),
        .locked   (locked)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        cyc = 0; ref_cyc = 0; have_ref = 0; prev_good = 0; prev_per = 0;
        m_period = 0; m_ovf = 0; m_valid = 0; m_lost = 0; m_locked = 0;
    endtask

    // Drive one cycle of inputs, clock it, advance the model, settle
    task automatic step(input bit e, input bit p, input bit r);
        int  interval;
        int  per;
        bit  ov;
        bit  cap;
        bit  acc;
        ena = e; pulse_in = p; ready = r;
        @(posedge clk);
        cyc++;
        acc = m_valid && r;
        cap = 0;
        if (!e) begin
            have_ref = 0; prev_good = 0; m_locked = 0;
        end else if (p) begin
            if (have_ref) begin
                interval = cyc - ref_cyc;
                ov  = (interval > PMAX);
                per = ov ? PMAX : interval;
                cap = 1;
                m_locked  = prev_good && !ov && (per == prev_per);
                prev_per  = per;
                prev_good = !ov;
            end
            have_ref = 1;
            ref_cyc  = cyc;
        end
        if (cap) begin
            if (m_valid && !r) m_lost = 1;
            else if (acc)      m_lost = 0;
            m_valid = 1; m_period = per; m_ovf = ov;
        end else if (acc) begin
            m_valid = 0; m_lost = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b0; pulse_in = 1'b0; ready = 1'b0;
        model_reset();
        #2;
        checks++;
        if ({valid, period, overflow, lost, locked} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%0b p=%0d o=%0b l=%0b k=%0b exp all 0",
                     valid, period, overflow, lost, locked);
        end
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0);
        checks++;
        if (valid !== 1'b0 || period !== '0) begin
            errors++;
            $display("FAIL reset_hold got v=%0b p=%0d exp v=0 p=0", valid, period);
        end
    endtask

    task automatic test_steady();
        step(0, 0, 1);
        step(1, 1, 1);
        for (int k = 0; k < 5; k++) begin
            repeat (4) step(1, 0, 1);
            step(1, 1, 1);
            checks++;
            if (valid !== 1'b1) begin
                errors++; $display("FAIL steady_valid k=%0d got %0b exp 1", k, valid);
            end
            checks++;
            if (period !== N'(5) || overflow !== 1'b0) begin
                errors++;
                $display("FAIL steady_period k=%0d got %0d/%0b exp 5/0", k, period, overflow);
            end
            checks++;
            if (locked !== (k > 0)) begin
                errors++;
                $display("FAIL steady_locked k=%0d got %0b exp %0b", k, locked, k > 0);
            end
        end
    endtask

    task automatic test_back_to_back();
        step(0, 0, 1);
        step(1, 1, 1);
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 1);
            checks++;
            if (valid !== 1'b1 || period !== N'(1)) begin
                errors++;
                $display("FAIL b2b k=%0d got v=%0b p=%0d exp v=1 p=1", k, valid, period);
            end
        end
        step(1, 0, 1);
        checks++;
        if (valid !== 1'b0) begin
            errors++; $display("FAIL b2b_drain got v=%0b exp 0", valid);
        end
    endtask

    task automatic test_overflow();
        step(0, 0, 1);
        step(1, 1, 1);
        repeat (299) step(1, 0, 1);
        step(1, 1, 1);
        checks++;
        if (valid !== 1'b1 || period !== N'(PMAX) || overflow !== 1'b1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL ovf_sat got v=%0b p=%0d o=%0b k=%0b exp 1/255/1/0",
                     valid, period, overflow, locked);
        end
        repeat (9) step(1, 0, 1);
        step(1, 1, 1);
        checks++;
        if (period !== N'(10) || overflow !== 1'b0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL ovf_recover got p=%0d o=%0b k=%0b exp 10/0/0", period, overflow, locked);
        end
    endtask

    task automatic test_backpressure();
        step(0, 0, 1);
        step(1, 1, 0);
        repeat (6) step(1, 0, 0);
        step(1, 1, 0);
        checks++;
        if (valid !== 1'b1 || period !== N'(7) || lost !== 1'b0) begin
            errors++;
            $display("FAIL bp_first got v=%0b p=%0d l=%0b exp 1/7/0", valid, period, lost);
        end
        repeat (8) step(1, 0, 0);
        checks++;
        if (valid !== 1'b1 || period !== N'(7)) begin
            errors++;
            $display("FAIL bp_stable got v=%0b p=%0d exp 1/7", valid, period);
        end
        step(1, 1, 0);
        checks++;
        if (valid !== 1'b1 || period !== N'(9) || lost !== 1'b1) begin
            errors++;
            $display("FAIL bp_overwrite got v=%0b p=%0d l=%0b exp 1/9/1", valid, period, lost);
        end
        step(1, 0, 1);
        checks++;
        if (valid !== 1'b0 || lost !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain got v=%0b l=%0b exp 0/0", valid, lost);
        end
    endtask

    task automatic test_enable_drop();
        step(0, 0, 1);
        step(1, 1, 1);
        repeat (3) step(1, 0, 1);
        step(0, 0, 1);
        step(0, 1, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        step(1, 1, 1);
        checks++;
        if (valid !== 1'b0) begin
            errors++; $display("FAIL ena_ref got v=%0b exp 0", valid);
        end
        repeat (5) step(1, 0, 1);
        step(1, 1, 1);
        checks++;
        if (valid !== 1'b1 || period !== N'(6) || locked !== 1'b0) begin
            errors++;
            $display("FAIL ena_result got v=%0b p=%0d k=%0b exp 1/6/0", valid, period, locked);
        end
    endtask

    task automatic test_async_reset();
        step(0, 0, 0);
        step(1, 1, 0);
        repeat (3) step(1, 0, 0);
        step(1, 1, 0);
        checks++;
        if (valid !== 1'b1 || period !== N'(4)) begin
            errors++; $display("FAIL arst_setup got v=%0b p=%0d exp 1/4", valid, period);
        end
        step(1, 0, 0);
        step(1, 0, 0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({valid, period, overflow, lost, locked} !== '0) begin
            errors++;
            $display("FAIL arst_immediate got v=%0b p=%0d o=%0b l=%0b k=%0b exp all 0",
                     valid, period, overflow, lost, locked);
        end
        #1 rst = 1'b0;
        model_reset();
        step(1, 1, 1);
        checks++;
        if (valid !== 1'b0) begin
            errors++; $display("FAIL arst_ref got v=%0b exp 0", valid);
        end
        repeat (3) step(1, 0, 1);
        step(1, 1, 1);
        checks++;
        if (valid !== 1'b1 || period !== N'(4) || locked !== 1'b0) begin
            errors++;
            $display("FAIL arst_first got v=%0b p=%0d k=%0b exp 1/4/0", valid, period, locked);
        end
    endtask

    task automatic test_random();
        int quiet = 0;
        bit e, p, r;
        step(0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            if (quiet > 0) begin
                e = 1; p = 0; quiet--;
            end else begin
                e = ($urandom_range(0, 19) != 0);
                p = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 199) == 0) quiet = $urandom_range(240, 270);
            end
            r = ($urandom_range(0, 2) != 0);
            step(e, p, r);
            checks++;
            if ({valid, period, overflow, lost, locked} !==
                {m_valid, N'(m_period), m_ovf, m_lost, m_locked}) begin
                errors++;
                $display("FAIL random i=%0d got v=%0b p=%0d o=%0b l=%0b k=%0b exp v=%0b p=%0d o=%0b l=%0b k=%0b",
                         i, valid, period, overflow, lost, locked,
                         m_valid, m_period, m_ovf, m_lost, m_locked);
            end
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_back_to_back();
        test_overflow();
        test_backpressure();
        test_enable_drop();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
